// File: rtl/event_timestamper.sv
// event_timestamper: synchronises an asynchronous event line, detects rising
// edges and captures the free-running counter at each edge into a small
// first-word-fall-through FIFO drained over a valid/ready port. Loss is
// flagged by a sticky overflow bit and a saturating drop counter.
//
// Ports:
//   CLOCK_50        sole clock, rising edge
//   reset_n         synchronous active-low reset
//   counter_in      free-running 32-bit count, same clock domain
//   event_in        asynchronous event line
//   ts_ready        consumer ready
//   clear_overflow  one-cycle pulse, clears overflow and drop_count
//   ts_data         head-of-FIFO timestamp (registered)
//   ts_valid        FIFO non-empty (registered)
//   fifo_level      entries held, 0..DEPTH
//   overflow        sticky, set when an edge is dropped
//   drop_count      dropped edges, saturates at all-ones
module event_timestamper #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic [31:0]              counter_in,
  input  logic                     event_in,
  input  logic                     ts_ready,
  input  logic                     clear_overflow,
  output logic [31:0]              ts_data,
  output logic                     ts_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int unsigned TS_W   = 32;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned DROP_W = 16;

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   ev_s;
  logic                   rise;

  logic [TS_W-1:0]        mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr_n;
  logic [PTR_W-1:0]       wr_ptr_n;
  logic [LVL_W-1:0]       level_n;
  logic [TS_W-1:0]        head_n;
  logic                   full;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Synchroniser chain and one-cycle delayed copy for edge detection.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], event_in};
      prev <= ev_s;
    end
  end

  assign ev_s = sync[SYNC_STAGES-1];
  assign rise = ev_s & ~prev;

  // FIFO control: a push into a full FIFO is accepted only alongside a pop.
  always_comb begin
    full     = (fifo_level == LVL_W'(DEPTH));
    pop      = ts_valid & ts_ready;
    push     = rise & (~full | pop);
    drop     = rise & full & ~pop;
    rd_ptr_n = pop  ? rd_ptr + PTR_W'(1) : rd_ptr;
    wr_ptr_n = push ? wr_ptr + PTR_W'(1) : wr_ptr;
    level_n  = fifo_level + LVL_W'(push) - LVL_W'(pop);
    // The new head is the incoming timestamp when it lands in the slot that
    // becomes the read slot (FIFO empty, or emptied by this cycle's pop).
    if (push && (wr_ptr == rd_ptr_n)) begin
      head_n = counter_in;
    end else begin
      head_n = mem[rd_ptr_n];
    end
  end

  // Timestamp storage.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= counter_in;
    end
  end

  // Pointers, level and registered head/valid outputs.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      ts_valid   <= 1'b0;
      ts_data    <= '0;
    end else begin
      rd_ptr     <= rd_ptr_n;
      wr_ptr     <= wr_ptr_n;
      fifo_level <= level_n;
      ts_valid   <= (level_n != '0);
      ts_data    <= head_n;
    end
  end

  // Loss reporting; a drop in the same cycle as a clear wins.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        drop_count <= DROP_W'(1);
      end else if (drop_count != '1) begin
        drop_count <= drop_count + DROP_W'(1);
      end
    end else if (clear_overflow) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

endmodule

// File: tb/tb_event_timestamper.sv
// Self-checking bench for event_timestamper: table-driven overflow/clear
// rows, hand-written corner sequences and randomized backpressure, all
// checked each cycle against a queue-based reference model.
module tb_event_timestamper;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned LVL_W       = $clog2(DEPTH) + 1;

  logic              CLOCK_50 = 1'b0;
  logic              reset_n;
  logic [31:0]       counter_in;
  logic              event_in;
  logic              ts_ready;
  logic              clear_overflow;
  logic [31:0]       ts_data;
  logic              ts_valid;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;
  logic [15:0]       drop_count;

  always #5 CLOCK_50 = ~CLOCK_50;

  event_timestamper #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .CLOCK_50       (CLOCK_50),
    .reset_n        (reset_n),
    .counter_in     (counter_in),
    .event_in       (event_in),
    .ts_ready       (ts_ready),
    .clear_overflow (clear_overflow),
    .ts_data        (ts_data),
    .ts_valid       (ts_valid),
    .fifo_level     (fifo_level),
    .overflow       (overflow),
    .drop_count     (drop_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event history per cycle, expected queue contents.
  bit          hist[$];
  int          mcyc     = 0;
  int          last_rst = -1;
  logic [31:0] q[$];
  bit          m_ovf    = 1'b0;
  int          m_dc     = 0;
  bit          m_zero   = 1'b1;

  function automatic bit h(input int j);
    if (j < 0 || j <= last_rst) return 1'b0;
    return hist[j];
  endfunction

  task automatic model_step();
    bit rise, pop, full, drop;
    hist.push_back(event_in);
    if (!reset_n) begin
      q.delete();
      m_ovf    = 1'b0;
      m_dc     = 0;
      m_zero   = 1'b1;
      last_rst = mcyc;
    end else begin
      // Synchronised level in cycle c is event_in of cycle c-SYNC_STAGES.
      rise = h(mcyc - int'(SYNC_STAGES)) && !h(mcyc - int'(SYNC_STAGES) - 1);
      full = (q.size() == int'(DEPTH));
      pop  = (q.size() > 0) && ts_ready;
      drop = 1'b0;
      if (pop) void'(q.pop_front());
      if (rise) begin
        if (!full || pop) begin
          q.push_back(counter_in);
          m_zero = 1'b0;
        end else begin
          drop = 1'b1;
        end
      end
      if (drop) begin
        m_ovf = 1'b1;
        if (clear_overflow) m_dc = 1;
        else if (m_dc < 65535) m_dc++;
      end else if (clear_overflow) begin
        m_ovf = 1'b0;
        m_dc  = 0;
      end
    end
    mcyc++;
  endtask

  task automatic check_model();
    chk("model_valid", 32'(q.size() != 0), 32'(ts_valid));
    chk("model_level", 32'(fifo_level), 32'(q.size()));
    chk("model_overflow", 32'(overflow), 32'(m_ovf));
    chk("model_drop_count", 32'(drop_count), 32'(m_dc));
    if (q.size() > 0) chk("model_data", ts_data, q[0]);
    else if (m_zero)  chk("model_data_after_reset", ts_data, 32'd0);
  endtask

  task automatic run_cycle();
    model_step();
    @(posedge CLOCK_50);
    #1;
    counter_in = counter_in + 32'd1;
    check_model();
  endtask

  task automatic step(input bit ev, input bit rdy, input bit clr);
    reset_n        = 1'b1;
    event_in       = ev;
    ts_ready       = rdy;
    clear_overflow = clr;
    run_cycle();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(ts_valid), 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    chk({tag, "_data"}, ts_data, 32'd0);
  endtask

  typedef struct {
    bit ev;
    int rdy_cyc;
    int clr_cyc;
    bit exp_valid;
    int exp_level;
    bit exp_ovf;
    int exp_dc;
  } row_t;

  row_t        rows[10];
  logic [31:0] start_cnt[10];
  logic [31:0] popped[$];
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic rand_cycle(input bit ev, input bit rdy);
    if (prev_stall) begin
      chk("stall_data_stable", ts_data, prev_data);
      chk("stall_valid_stable", 32'(ts_valid), 32'd1);
    end
    if (ts_valid && rdy) popped.push_back(ts_data);
    prev_stall = ts_valid && !rdy;
    prev_data  = ts_data;
    step(ev, rdy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_ts;
    int          hi, gap;

    // Rows: each is 4 cycles, event high in cycles 0-1 when ev is set.
    rows[0] = '{1, -1, -1, 1, 1, 0, 0};
    rows[1] = '{1, -1, -1, 1, 2, 0, 0};
    rows[2] = '{1, -1, -1, 1, 3, 0, 0};
    rows[3] = '{1, -1, -1, 1, 4, 0, 0};
    rows[4] = '{1, -1, -1, 1, 4, 1, 1};
    rows[5] = '{1, -1, -1, 1, 4, 1, 2};
    rows[6] = '{0, -1,  0, 1, 4, 0, 0};  // clear leaves FIFO untouched
    rows[7] = '{1,  2, -1, 1, 4, 0, 0};  // full, push with pop same cycle
    rows[8] = '{1, -1,  2, 1, 4, 1, 1};  // drop coincides with clear
    rows[9] = '{0,  0, -1, 1, 3, 1, 1};

    reset_n        = 1'b0;
    event_in       = 1'b0;
    ts_ready       = 1'b0;
    clear_overflow = 1'b0;
    counter_in     = 32'h1234_0000;
    run_cycle();
    chk_all_zero("reset");

    // Single event: counter 0 in cycle 0, event sampled at edge 10.
    counter_in = 32'd0;
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("single_valid_edge11", 32'(ts_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("single_valid_edge12", 32'(ts_valid), 32'd1);
    chk("single_data", ts_data, 32'd11);
    chk("single_level", 32'(fifo_level), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("single_drained", 32'(fifo_level), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);

    // Table-driven overflow / clear / full push-pop rows.
    for (int r = 0; r < 10; r++) begin
      start_cnt[r] = counter_in;
      for (int k = 0; k < 4; k++)
        step(rows[r].ev && (k < 2), k == rows[r].rdy_cyc, k == rows[r].clr_cyc);
      chk($sformatf("row%0d_valid", r), 32'(ts_valid), 32'(rows[r].exp_valid));
      chk($sformatf("row%0d_level", r), 32'(fifo_level), 32'(rows[r].exp_level));
      chk($sformatf("row%0d_overflow", r), 32'(overflow), 32'(rows[r].exp_ovf));
      chk($sformatf("row%0d_drop_count", r), 32'(drop_count), 32'(rows[r].exp_dc));
      if (r == 5) chk("row5_head_first_ts", ts_data, start_cnt[0] + 32'd2);
      if (r == 7) chk("row7_head_second_ts", ts_data, start_cnt[1] + 32'd2);
    end
    popped.delete();
    for (int i = 0; i < 8; i++) begin
      if (ts_valid) popped.push_back(ts_data);
      step(1'b0, 1'b1, 1'b0);
    end
    chk("drain_count", 32'(popped.size()), 32'd3);
    if (popped.size() == 3) chk("drain_tail_ts", popped[2], start_cnt[7] + 32'd2);
    step(1'b0, 1'b0, 1'b1);
    chk("clear_overflow", 32'(overflow), 32'd0);
    chk("clear_drop_count", 32'(drop_count), 32'd0);

    // Wrap-around: captures at 0xFFFFFFFF and 0x00000003.
    counter_in = 32'hFFFF_FFFD;
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    chk("wrap_level", 32'(fifo_level), 32'd2);
    chk("wrap_first", ts_data, 32'hFFFF_FFFF);
    step(1'b0, 1'b1, 1'b0);
    chk("wrap_second", ts_data, 32'h0000_0003);
    step(1'b0, 1'b1, 1'b0);
    chk("wrap_drained", 32'(ts_valid), 32'd0);

    // Reset mid-operation with event held high through reset.
    for (int p = 0; p < 3; p++)
      for (int k = 0; k < 4; k++) step(k < 2, 1'b0, 1'b0);
    chk("pre_reset_level", 32'(fifo_level), 32'd3);
    reset_n  = 1'b0;
    event_in = 1'b1;
    ts_ready = 1'b0;
    run_cycle();
    chk_all_zero("midreset");
    exp_ts = counter_in + 32'd2;
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_valid_1", 32'(ts_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_valid_2", 32'(ts_valid), 32'd0);
    step(1'b1, 1'b0, 1'b0);
    chk("post_reset_valid_3", 32'(ts_valid), 32'd1);
    chk("post_reset_data", ts_data, exp_ts);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    chk("post_reset_single", 32'(fifo_level), 32'd1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);

    // Randomized backpressure over 100 events.
    popped.delete();
    for (int e = 0; e < 100; e++) begin
      hi  = int'($urandom_range(1, 4));
      gap = int'($urandom_range(8, 12));
      for (int i = 0; i < gap; i++) rand_cycle(i < hi, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 40; i++) rand_cycle(1'b0, 1'b1);
    chk("rand_count", 32'(popped.size()), 32'd100);
    for (int i = 1; i < popped.size(); i++)
      chk($sformatf("rand_increasing_%0d", i), 32'(popped[i] > popped[i-1]), 32'd1);
    chk("rand_no_overflow", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
